// File: rtl/aes_visc_pkg.sv
// Shared AES types, constants and the InvShiftRows permutation for the VISC decrypt datapath.
package aes_visc_pkg;

  localparam int AES_NB     = 4;
  localparam int AES_NBYTES = 16;

  typedef logic [127:0] aes_block_t;
  typedef logic [7:0]   aes_byte_t;

  // Byte i lives at block[127-8i -: 8]; state[r][c] is byte 4c+r, and row r rotates right by r.
  function automatic aes_block_t inv_shift_rows(input aes_block_t blk);
    aes_block_t res;
    int src;
    res = '0;
    for (int c = 0; c < AES_NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = 4 * ((c + AES_NB - r) % AES_NB) + r;
        res[127 - 8 * (4 * c + r) -: 8] = blk[127 - 8 * src -: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_inv_sbox_visc.sv
// Combinational AES inverse S-box, one byte in, one byte out.
module aes_inv_sbox_visc
  import aes_visc_pkg::*;
(
  input  aes_byte_t a,
  output aes_byte_t y
);

  always_comb begin
    y = 8'h00;
    case (a)
      8'h00: y = 8'h52; 8'h01: y = 8'h09; 8'h02: y = 8'h6a; 8'h03: y = 8'hd5;
      8'h04: y = 8'h30; 8'h05: y = 8'h36; 8'h06: y = 8'ha5; 8'h07: y = 8'h38;
      8'h08: y = 8'hbf; 8'h09: y = 8'h40; 8'h0a: y = 8'ha3; 8'h0b: y = 8'h9e;
      8'h0c: y = 8'h81; 8'h0d: y = 8'hf3; 8'h0e: y = 8'hd7; 8'h0f: y = 8'hfb;
      8'h10: y = 8'h7c; 8'h11: y = 8'he3; 8'h12: y = 8'h39; 8'h13: y = 8'h82;
      8'h14: y = 8'h9b; 8'h15: y = 8'h2f; 8'h16: y = 8'hff; 8'h17: y = 8'h87;
      8'h18: y = 8'h34; 8'h19: y = 8'h8e; 8'h1a: y = 8'h43; 8'h1b: y = 8'h44;
      8'h1c: y = 8'hc4; 8'h1d: y = 8'hde; 8'h1e: y = 8'he9; 8'h1f: y = 8'hcb;
      8'h20: y = 8'h54; 8'h21: y = 8'h7b; 8'h22: y = 8'h94; 8'h23: y = 8'h32;
      8'h24: y = 8'ha6; 8'h25: y = 8'hc2; 8'h26: y = 8'h23; 8'h27: y = 8'h3d;
      8'h28: y = 8'hee; 8'h29: y = 8'h4c; 8'h2a: y = 8'h95; 8'h2b: y = 8'h0b;
      8'h2c: y = 8'h42; 8'h2d: y = 8'hfa; 8'h2e: y = 8'hc3; 8'h2f: y = 8'h4e;
      8'h30: y = 8'h08; 8'h31: y = 8'h2e; 8'h32: y = 8'ha1; 8'h33: y = 8'h66;
      8'h34: y = 8'h28; 8'h35: y = 8'hd9; 8'h36: y = 8'h24; 8'h37: y = 8'hb2;
      8'h38: y = 8'h76; 8'h39: y = 8'h5b; 8'h3a: y = 8'ha2; 8'h3b: y = 8'h49;
      8'h3c: y = 8'h6d; 8'h3d: y = 8'h8b; 8'h3e: y = 8'hd1; 8'h3f: y = 8'h25;
      8'h40: y = 8'h72; 8'h41: y = 8'hf8; 8'h42: y = 8'hf6; 8'h43: y = 8'h64;
      8'h44: y = 8'h86; 8'h45: y = 8'h68; 8'h46: y = 8'h98; 8'h47: y = 8'h16;
      8'h48: y = 8'hd4; 8'h49: y = 8'ha4; 8'h4a: y = 8'h5c; 8'h4b: y = 8'hcc;
      8'h4c: y = 8'h5d; 8'h4d: y = 8'h65; 8'h4e: y = 8'hb6; 8'h4f: y = 8'h92;
      8'h50: y = 8'h6c; 8'h51: y = 8'h70; 8'h52: y = 8'h48; 8'h53: y = 8'h50;
      8'h54: y = 8'hfd; 8'h55: y = 8'hed; 8'h56: y = 8'hb9; 8'h57: y = 8'hda;
      8'h58: y = 8'h5e; 8'h59: y = 8'h15; 8'h5a: y = 8'h46; 8'h5b: y = 8'h57;
      8'h5c: y = 8'ha7; 8'h5d: y = 8'h8d; 8'h5e: y = 8'h9d; 8'h5f: y = 8'h84;
      8'h60: y = 8'h90; 8'h61: y = 8'hd8; 8'h62: y = 8'hab; 8'h63: y = 8'h00;
      8'h64: y = 8'h8c; 8'h65: y = 8'hbc; 8'h66: y = 8'hd3; 8'h67: y = 8'h0a;
      8'h68: y = 8'hf7; 8'h69: y = 8'he4; 8'h6a: y = 8'h58; 8'h6b: y = 8'h05;
      8'h6c: y = 8'hb8; 8'h6d: y = 8'hb3; 8'h6e: y = 8'h45; 8'h6f: y = 8'h06;
      8'h70: y = 8'hd0; 8'h71: y = 8'h2c; 8'h72: y = 8'h1e; 8'h73: y = 8'h8f;
      8'h74: y = 8'hca; 8'h75: y = 8'h3f; 8'h76: y = 8'h0f; 8'h77: y = 8'h02;
      8'h78: y = 8'hc1; 8'h79: y = 8'haf; 8'h7a: y = 8'hbd; 8'h7b: y = 8'h03;
      8'h7c: y = 8'h01; 8'h7d: y = 8'h13; 8'h7e: y = 8'h8a; 8'h7f: y = 8'h6b;
      8'h80: y = 8'h3a; 8'h81: y = 8'h91; 8'h82: y = 8'h11; 8'h83: y = 8'h41;
      8'h84: y = 8'h4f; 8'h85: y = 8'h67; 8'h86: y = 8'hdc; 8'h87: y = 8'hea;
      8'h88: y = 8'h97; 8'h89: y = 8'hf2; 8'h8a: y = 8'hcf; 8'h8b: y = 8'hce;
      8'h8c: y = 8'hf0; 8'h8d: y = 8'hb4; 8'h8e: y = 8'he6; 8'h8f: y = 8'h73;
      8'h90: y = 8'h96; 8'h91: y = 8'hac; 8'h92: y = 8'h74; 8'h93: y = 8'h22;
      8'h94: y = 8'he7; 8'h95: y = 8'had; 8'h96: y = 8'h35; 8'h97: y = 8'h85;
      8'h98: y = 8'he2; 8'h99: y = 8'hf9; 8'h9a: y = 8'h37; 8'h9b: y = 8'he8;
      8'h9c: y = 8'h1c; 8'h9d: y = 8'h75; 8'h9e: y = 8'hdf; 8'h9f: y = 8'h6e;
      8'ha0: y = 8'h47; 8'ha1: y = 8'hf1; 8'ha2: y = 8'h1a; 8'ha3: y = 8'h71;
      8'ha4: y = 8'h1d; 8'ha5: y = 8'h29; 8'ha6: y = 8'hc5; 8'ha7: y = 8'h89;
      8'ha8: y = 8'h6f; 8'ha9: y = 8'hb7; 8'haa: y = 8'h62; 8'hab: y = 8'h0e;
      8'hac: y = 8'haa; 8'had: y = 8'h18; 8'hae: y = 8'hbe; 8'haf: y = 8'h1b;
      8'hb0: y = 8'hfc; 8'hb1: y = 8'h56; 8'hb2: y = 8'h3e; 8'hb3: y = 8'h4b;
      8'hb4: y = 8'hc6; 8'hb5: y = 8'hd2; 8'hb6: y = 8'h79; 8'hb7: y = 8'h20;
      8'hb8: y = 8'h9a; 8'hb9: y = 8'hdb; 8'hba: y = 8'hc0; 8'hbb: y = 8'hfe;
      8'hbc: y = 8'h78; 8'hbd: y = 8'hcd; 8'hbe: y = 8'h5a; 8'hbf: y = 8'hf4;
      8'hc0: y = 8'h1f; 8'hc1: y = 8'hdd; 8'hc2: y = 8'ha8; 8'hc3: y = 8'h33;
      8'hc4: y = 8'h88; 8'hc5: y = 8'h07; 8'hc6: y = 8'hc7; 8'hc7: y = 8'h31;
      8'hc8: y = 8'hb1; 8'hc9: y = 8'h12; 8'hca: y = 8'h10; 8'hcb: y = 8'h59;
      8'hcc: y = 8'h27; 8'hcd: y = 8'h80; 8'hce: y = 8'hec; 8'hcf: y = 8'h5f;
      8'hd0: y = 8'h60; 8'hd1: y = 8'h51; 8'hd2: y = 8'h7f; 8'hd3: y = 8'ha9;
      8'hd4: y = 8'h19; 8'hd5: y = 8'hb5; 8'hd6: y = 8'h4a; 8'hd7: y = 8'h0d;
      8'hd8: y = 8'h2d; 8'hd9: y = 8'he5; 8'hda: y = 8'h7a; 8'hdb: y = 8'h9f;
      8'hdc: y = 8'h93; 8'hdd: y = 8'hc9; 8'hde: y = 8'h9c; 8'hdf: y = 8'hef;
      8'he0: y = 8'ha0; 8'he1: y = 8'he0; 8'he2: y = 8'h3b; 8'he3: y = 8'h4d;
      8'he4: y = 8'hae; 8'he5: y = 8'h2a; 8'he6: y = 8'hf5; 8'he7: y = 8'hb0;
      8'he8: y = 8'hc8; 8'he9: y = 8'heb; 8'hea: y = 8'hbb; 8'heb: y = 8'h3c;
      8'hec: y = 8'h83; 8'hed: y = 8'h53; 8'hee: y = 8'h99; 8'hef: y = 8'h61;
      8'hf0: y = 8'h17; 8'hf1: y = 8'h2b; 8'hf2: y = 8'h04; 8'hf3: y = 8'h7e;
      8'hf4: y = 8'hba; 8'hf5: y = 8'h77; 8'hf6: y = 8'hd6; 8'hf7: y = 8'h26;
      8'hf8: y = 8'he1; 8'hf9: y = 8'h69; 8'hfa: y = 8'h14; 8'hfb: y = 8'h63;
      8'hfc: y = 8'h55; 8'hfd: y = 8'h21; 8'hfe: y = 8'h0c; 8'hff: y = 8'h7d;
    endcase
  end

endmodule

// File: rtl/aes_inv_first_round_visc.sv
// Decrypt entry round: AddRoundKey(K10) + InvShiftRows in stage 1, InvSubBytes in stage 2.
// Optional block counter output blk_cnt enabled by defining AES_INV_ROUND_PERF_EN.
module aes_inv_first_round_visc
  import aes_visc_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int KEY_W  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [KEY_W-1:0]  key_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out
`ifdef AES_INV_ROUND_PERF_EN
  ,
  output logic [31:0]       blk_cnt
`endif
);

  if (DATA_W != 128 || KEY_W != DATA_W) begin : g_bad_width
    $error("aes_inv_first_round_visc: DATA_W and KEY_W must both be 128");
  end

  logic       v1, v2;
  aes_block_t s1, s2;
  aes_block_t sub_s1;
  logic       adv1, adv2;

  // Ready ripples back combinationally; a full pipe only stalls when the consumer does.
  assign adv2     = ~v2 | out_ready;
  assign adv1     = ~v1 | adv2;
  assign in_ready = adv1;

  for (genvar i = 0; i < AES_NBYTES; i++) begin : g_sbox
    aes_inv_sbox_visc u_sbox (
      .a(s1[127 - 8 * i -: 8]),
      .y(sub_s1[127 - 8 * i -: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      s1 <= '0;
      s2 <= '0;
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        if (in_valid) s1 <= inv_shift_rows(data_in ^ key_in);
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) s2 <= sub_s1;
      end
    end
  end

  assign out_valid = v2;
  assign data_out  = s2;

`ifdef AES_INV_ROUND_PERF_EN
  logic [31:0] blk_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                     blk_cnt_q <= '0;
    else if (v2 && out_ready)    blk_cnt_q <= blk_cnt_q + 32'd1;
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_inv_first_round_visc.sv
// Scoreboard bench for aes_inv_first_round_visc: directed vectors, back-pressure, reset flush.
module tb_aes_inv_first_round_visc;

  typedef struct {
    logic [127:0] exp;
    int           acc;
    bit           lat;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] data_in = '0;
  logic [127:0] key_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] data_out;
`ifdef AES_INV_ROUND_PERF_EN
  logic [31:0]  blk_cnt;
`endif

  int           tests_run = 0;
  int           tests_failed = 0;
  int           cyc = 0;
  int           n_recv = 0;
  int           n_mark;
  sb_t          sb[$];
  bit           stall_prev = 0;
  logic [127:0] held = '0;
  logic [127:0] vec_d[8];
  logic [127:0] vec_k[8];
  logic [127:0] vec_e[8];

  aes_inv_first_round_visc dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .key_in(key_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out)
`ifdef AES_INV_ROUND_PERF_EN
    ,
    .blk_cnt(blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offers one block; returns at posedge+1 after it is accepted (or after a bounded wait).
  task automatic applyStimulus(input logic [127:0] d, input logic [127:0] k,
                               input logic [127:0] e, input bit lat);
    int budget;
    sb_t item;
    budget   = 0;
    in_valid = 1'b1;
    data_in  = d;
    key_in   = k;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        item.exp = e;
        item.acc = cyc;
        item.lat = lat;
        sb.push_back(item);
        @(posedge clk);
        #1;
        break;
      end
      budget++;
      if (budget > 50) begin
        checkOutput("accept_timeout", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    checkOutput(name, 128'(sb.size()), 128'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 0;
        continue;
      end
      if (stall_prev) begin
        checkOutput("stall_hold", data_out, held);
        checkOutput("stall_valid", 128'(out_valid), 128'd1);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_output: got %h expected no output", data_out);
        end else begin
          e = sb.pop_front();
          checkOutput("data_out", data_out, e.exp);
          if (e.lat) checkOutput("latency", 128'(cyc - e.acc), 128'd2);
          n_recv++;
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = data_out;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_d[0] = 128'h3925841d02dc09fbdc118597196a0b32;
    vec_k[0] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    vec_e[0] = 128'heb40f21e592e38848ba113e71bc342d2;
    vec_d[1] = 128'h637c777bf26b6fc53001672bfed7ab76;
    vec_k[1] = '0;
    vec_e[1] = 128'h000d0a07_04010e0b_0805020f_0c090603;
    vec_d[2] = '0; vec_k[2] = {16{8'h01}}; vec_e[2] = {16{8'h09}};
    vec_d[3] = '0; vec_k[3] = {16{8'h02}}; vec_e[3] = {16{8'h6a}};
    vec_d[4] = '0; vec_k[4] = {16{8'h10}}; vec_e[4] = {16{8'h7c}};
    vec_d[5] = '0; vec_k[5] = {16{8'h20}}; vec_e[5] = {16{8'h54}};
    vec_d[6] = '0; vec_k[6] = {16{8'hff}}; vec_e[6] = {16{8'h7d}};
    vec_d[7] = {16{8'h63}}; vec_k[7] = '0; vec_e[7] = '0;

    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
    checkOutput("reset_data_out", data_out, 128'd0);
    checkOutput("reset_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;

    // Single blocks with latency checked: FIPS vector, S-box corners, InvShiftRows pattern.
    applyStimulus(vec_d[0], vec_k[0], vec_e[0], 1);
    waitDrain("drain_fips");
    applyStimulus({16{8'h63}}, 128'd0, 128'd0, 1);
    applyStimulus(128'd0, 128'd0, {16{8'h52}}, 1);
    applyStimulus(128'd0, {16{8'h7d}}, {16{8'h13}}, 1);
    applyStimulus(vec_d[1], vec_k[1], vec_e[1], 1);
    waitDrain("drain_corners");

    // Back-to-back stream with a 5-cycle downstream stall starting at cycle 3.
    n_mark = n_recv;
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(vec_d[i], vec_k[i], vec_e[i], 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_in_ready_low", 128'(in_ready), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain("drain_bp");
    checkOutput("bp_count", 128'(n_recv - n_mark), 128'd8);

    // Two blocks in flight, then a 1-cycle reset with in_valid held high.
    out_ready = 1'b0;
    applyStimulus(vec_d[2], vec_k[2], vec_e[2], 0);
    applyStimulus(vec_d[3], vec_k[3], vec_e[3], 0);
    rst      = 1'b1;
    in_valid = 1'b1;
    data_in  = vec_d[4];
    key_in   = vec_k[4];
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("midrst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("midrst_data_out", data_out, 128'd0);
    checkOutput("midrst_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    n_mark = n_recv;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midrst_no_stale", 128'(n_recv - n_mark), 128'd0);

`ifdef AES_INV_ROUND_PERF_EN
    for (int i = 0; i < 10; i++) applyStimulus(vec_d[i % 8], vec_k[i % 8], vec_e[i % 8], 0);
    waitDrain("drain_perf");
    @(negedge clk);
    checkOutput("blk_cnt_10", 128'(blk_cnt), 128'd10);
    @(posedge clk);
    #1;
    force dut.blk_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.blk_cnt_q;
    applyStimulus(vec_d[0], vec_k[0], vec_e[0], 0);
    waitDrain("drain_wrap");
    @(negedge clk);
    checkOutput("blk_cnt_wrap", 128'(blk_cnt), 128'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
